// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: circular byte buffer between the UART receiver and transmitter.
// Each rising edge of rec_flag stores one byte. A small read sequencer hands the
// stored bytes to the transmitter one at a time, using a send_start/tx_busy handshake.
// The read sequencer gives up on a missing tx_busy acknowledge after ACK_TIMEOUT cycles.
module uart_byte_fifo #(
   parameter int DATA_W      = 8,
   parameter int DEPTH_LOG2  = 4,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic [DATA_W-1:0]     rec_data,
   input  logic                  rec_flag,
   input  logic                  tx_busy,
   output logic [DATA_W-1:0]     send_data,
   output logic                  send_start,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  overflow,
   output logic [7:0]            drop_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   // Storage: written on accepted pushes, read through the send_data register.
   logic [DATA_W-1:0]     mem [DEPTH];

   logic [DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [DEPTH_LOG2:0]   count_reg;
   logic [DEPTH_LOG2:0]   count_next;
   logic                  empty_reg;
   logic                  full_reg;
   logic                  rec_flag_d_reg;
   logic                  overflow_reg;
   logic [7:0]            drop_cnt_reg;
   state_t                state_reg;
   logic [TMO_W-1:0]      tmo_reg;
   logic [DATA_W-1:0]     send_data_reg;
   logic                  send_start_reg;

   logic                  wr_en;
   logic                  pop;
   logic                  push;
   logic                  drop;

   // A pop happens on the edge that moves the sequencer from IDLE to LOAD.
   // A write into a full FIFO is only accepted when that same edge frees a slot.
   always_comb begin
      wr_en      = rec_flag & ~rec_flag_d_reg;
      pop        = (state_reg == IDLE) && !empty_reg && !tx_busy;
      push       = wr_en && (!full_reg || pop);
      drop       = wr_en && full_reg && !pop;
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + 1'b1;
      end else if (pop && !push) begin
         count_next = count_reg - 1'b1;
      end
   end

   // Write side: edge detect on rec_flag, write pointer, occupancy flags, drop accounting.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rec_flag_d_reg <= 1'b1;
         wr_ptr_reg     <= '0;
         count_reg      <= '0;
         empty_reg      <= 1'b1;
         full_reg       <= 1'b0;
         overflow_reg   <= 1'b0;
         drop_cnt_reg   <= '0;
      end else begin
         rec_flag_d_reg <= rec_flag;
         count_reg      <= count_next;
         empty_reg      <= (count_next == '0);
         full_reg       <= (count_next == FULL_COUNT);
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
               drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
         end
      end
   end

   // Memory array write port; kept free of reset so it maps onto block RAM.
   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= rec_data;
      end
   end

   // Read sequencer: present a byte, then wait for the transmitter to take it and finish.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_reg      <= IDLE;
         rd_ptr_reg     <= '0;
         tmo_reg        <= '0;
         send_data_reg  <= '0;
         send_start_reg <= 1'b0;
      end else begin
         send_start_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  send_data_reg  <= mem[rd_ptr_reg];
                  rd_ptr_reg     <= rd_ptr_reg + 1'b1;
                  send_start_reg <= 1'b1;
                  state_reg      <= LOAD;
               end
            end
            LOAD: begin
               tmo_reg   <= '0;
               state_reg <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state_reg <= WAIT_DONE;
               end else if (tmo_reg == TMO_LAST) begin
                  // No acknowledge: treat the byte as sent and move on.
                  state_reg <= IDLE;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign send_data  = send_data_reg;
   assign send_start = send_start_reg;
   assign fifo_count = count_reg;
   assign fifo_empty = empty_reg;
   assign fifo_full  = full_reg;
   assign overflow   = overflow_reg;
   assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Bench for uart_byte_fifo: a queue-based reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_uart_byte_fifo;

   localparam int DEPTH = 16;
   localparam int TMO   = 1024;

   logic       sys_clk  = 1'b0;
   logic       sys_rst  = 1'b1;
   logic [7:0] rec_data = 8'h00;
   logic       rec_flag = 1'b1;
   logic       tx_busy  = 1'b0;
   logic [7:0] send_data;
   logic       send_start;
   logic [4:0] fifo_count;
   logic       fifo_empty;
   logic       fifo_full;
   logic       overflow;
   logic [7:0] drop_cnt;

   uart_byte_fifo #(
      .DATA_W      (8),
      .DEPTH_LOG2  (4),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .rec_data   (rec_data),
      .rec_flag   (rec_flag),
      .tx_busy    (tx_busy),
      .send_data  (send_data),
      .send_start (send_start),
      .fifo_count (fifo_count),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] mq[$];
   bit         m_prev      = 1'b1;
   bit         m_ovf       = 1'b0;
   int         m_drops     = 0;
   bit         m_start     = 1'b0;
   logic [7:0] m_data      = 8'h00;
   bit         m_free      = 1'b1;
   bit         m_busy_seen = 1'b0;
   longint     m_tsend     = 0;
   longint     edge_n      = 0;
   bit         m_valid     = 1'b0;
   logic [7:0] sent_log[$];
   longint     start_edges[$];

   // Model update from the inputs sampled at this edge, then compare after the edge.
   always @(posedge sys_clk) begin
      bit do_push;
      bit do_pop;
      edge_n++;
      if (sys_rst) begin
         mq.delete();
         m_prev      = 1'b1;
         m_ovf       = 1'b0;
         m_drops     = 0;
         m_start     = 1'b0;
         m_data      = 8'h00;
         m_free      = 1'b1;
         m_busy_seen = 1'b0;
         m_valid     = 1'b1;
      end else begin
         do_pop  = m_free && (mq.size() != 0) && !tx_busy;
         do_push = rec_flag && !m_prev;
         m_prev  = rec_flag;
         // Retire the byte in flight: acknowledged then released, or never acknowledged in time.
         if (!m_free) begin
            if (!m_busy_seen) begin
               if (edge_n >= m_tsend + 2 && tx_busy) m_busy_seen = 1'b1;
               else if (edge_n == m_tsend + 1 + TMO) m_free = 1'b1;
            end else if (!tx_busy) begin
               m_free = 1'b1;
            end
         end
         m_start = do_pop;
         if (do_pop) begin
            m_data      = mq.pop_front();
            m_free      = 1'b0;
            m_busy_seen = 1'b0;
            m_tsend     = edge_n;
         end
         if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(rec_data);
            else begin
               m_ovf = 1'b1;
               if (m_drops < 255) m_drops++;
            end
         end
      end
      #1;
      if (m_valid) begin
         check("count",      32'(fifo_count), 32'(mq.size()));
         check("empty",      32'(fifo_empty), 32'(mq.size() == 0));
         check("full",       32'(fifo_full),  32'(mq.size() == DEPTH));
         check("overflow",   32'(overflow),   32'(m_ovf));
         check("drop_cnt",   32'(drop_cnt),   32'(m_drops));
         check("send_start", 32'(send_start), 32'(m_start));
         check("send_data",  32'(send_data),  32'(m_data));
         if (send_start === 1'b1) begin
            sent_log.push_back(send_data);
            start_edges.push_back(edge_n);
         end
      end
   end

   // ---------------- transmitter stand-in ----------------
   // mode 0: answers each send_start with a random delay/length busy pulse
   // mode 1: busy held high; mode 2: never busy
   int tx_mode = 2;
   int dly     = 0;
   int len     = 0;

   always @(posedge sys_clk) begin
      #2;
      if (tx_mode == 1) begin
         tx_busy = 1'b1;
         dly = 0;
         len = 0;
      end else if (tx_mode == 2) begin
         tx_busy = 1'b0;
         dly = 0;
         len = 0;
      end else if (send_start === 1'b1) begin
         dly = int'($urandom_range(0, 2));
         len = ($urandom_range(0, 29) == 0) ? 0 : int'($urandom_range(1, 6));
         tx_busy = 1'b0;
      end else if (dly > 0) begin
         dly--;
      end else if (len > 0) begin
         tx_busy = 1'b1;
         len--;
      end else begin
         tx_busy = 1'b0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_byte(input logic [7:0] b);
      @(negedge sys_clk);
      rec_data = b;
      rec_flag = 1'b1;
      @(negedge sys_clk);
      rec_flag = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge sys_clk);
         if (m_free && mq.size() == 0 && tx_busy == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 32'd1);
      repeat (2) @(negedge sys_clk);
   endtask

   initial begin
      logic [7:0] exp5[17];

      // 1: reset with rec_flag held high; release must not write
      tx_mode  = 2;
      sys_rst  = 1'b1;
      rec_flag = 1'b1;
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("t1_count", 32'(fifo_count), 32'd0);
      check("t1_empty", 32'(fifo_empty), 32'd1);
      check("t1_start", 32'(send_start), 32'd0);
      rec_flag = 1'b0;
      @(negedge sys_clk);

      // 2: single byte latency with the transmitter idle
      tx_mode  = 0;
      rec_data = 8'hA5;
      rec_flag = 1'b1;
      @(posedge sys_clk); #1;
      check("t2_start_k",   32'(send_start), 32'd0);
      check("t2_count_k",   32'(fifo_count), 32'd1);
      @(posedge sys_clk); #1;
      check("t2_start_k1",  32'(send_start), 32'd1);
      check("t2_data",      32'(send_data),  32'hA5);
      check("t2_count_k1",  32'(fifo_count), 32'd0);
      @(posedge sys_clk); #1;
      check("t2_start_k2",  32'(send_start), 32'd0);
      @(negedge sys_clk);
      rec_flag = 1'b0;
      wait_idle("t2_idle", 200);

      // 3: fill with the transmitter busy (pointers start at 1, so they wrap)
      tx_mode = 1;
      repeat (2) @(negedge sys_clk);
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      check("t3_count", 32'(fifo_count), 32'd16);
      check("t3_full",  32'(fifo_full),  32'd1);
      check("t3_empty", 32'(fifo_empty), 32'd0);

      // 4: overflow accounting and saturation
      for (int i = 0; i < 3; i++) push_byte(8'hF0 + 8'(i));
      check("t4_ovf",   32'(overflow),   32'd1);
      check("t4_drop3", 32'(drop_cnt),   32'd3);
      check("t4_count", 32'(fifo_count), 32'd16);
      for (int i = 0; i < 300; i++) push_byte(8'(i));
      check("t4_drop255", 32'(drop_cnt), 32'd255);

      // 5: push lands on the same edge as the first pop of a full FIFO
      sent_log.delete();
      tx_mode = 0;
      @(negedge sys_clk);
      rec_data = 8'hEE;
      rec_flag = 1'b1;
      @(posedge sys_clk); #1;
      check("t5_count",   32'(fifo_count), 32'd16);
      check("t5_start",   32'(send_start), 32'd1);
      check("t5_data",    32'(send_data),  32'h00);
      check("t5_drop",    32'(drop_cnt),   32'd255);
      @(negedge sys_clk);
      rec_flag = 1'b0;
      wait_idle("t5_idle", 3000);
      for (int i = 0; i < 16; i++) exp5[i] = 8'(i);
      exp5[16] = 8'hEE;
      check("t5_nsent", 32'(sent_log.size()), 32'd17);
      for (int i = 0; i < 17 && i < sent_log.size(); i++) check("t5_order", 32'(sent_log[i]), 32'(exp5[i]));

      // 6: no acknowledge from the transmitter -> timeout, next byte still goes out
      tx_mode = 2;
      repeat (2) @(negedge sys_clk);
      sent_log.delete();
      start_edges.delete();
      push_byte(8'h3C);
      push_byte(8'h5A);
      for (int i = 0; i < 3000 && start_edges.size() < 2; i++) @(negedge sys_clk);
      check("t6_nsent", 32'(start_edges.size()), 32'd2);
      if (start_edges.size() >= 2) begin
         check("t6_gap",   32'(start_edges[1] - start_edges[0]), 32'(TMO + 2));
         check("t6_byte0", 32'(sent_log[0]), 32'h3C);
         check("t6_byte1", 32'(sent_log[1]), 32'h5A);
      end
      wait_idle("t6_idle", 3000);

      // Randomized traffic, one forced reset mid-stream and a forced-busy stretch
      tx_mode = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge sys_clk);
         if (i == 1000 || $urandom_range(0, 999) == 0) sys_rst = 1'b1;
         else sys_rst = 1'b0;
         if (i == 1500) tx_mode = 1;
         if (i == 1800) tx_mode = 0;
         if ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 70 : 25)) begin
            if (!rec_flag) rec_data = 8'($urandom);
            rec_flag = ~rec_flag;
         end
      end
      @(negedge sys_clk);
      sys_rst  = 1'b0;
      rec_flag = 1'b0;
      tx_mode  = 0;
      wait_idle("end_idle", 5000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
